// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for a 5-stage pipeline. It drives the write
// enables and bubble-insert controls of the PC and the IF/ID, ID/EX, EX/MEM
// and MEM/WB registers. It also runs the halt-drain sequence and keeps
// saturating stall and flush statistics.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   IF_ID_Rs, IF_ID_Rt        source registers of the instruction in ID
//   ID_uses_rs, ID_uses_rt    ID instruction actually reads Rs / Rt
//   ID_halt                   ID instruction is HLT
//   EX_memread, EX_regtowrite load in EX and its destination register
//   EX_branch_taken           branch/jump resolved taken in EX
//   imem_busy, dmem_busy      memory wait states
//   pc_wen .. mem_wb_wen      register write enables
//   if_id_flush, id_ex_flush  bubble insertion into IF/ID and ID/EX
//   halted                    pipeline drained after HLT
//   stall_cnt, flush_cnt      saturating statistics counters
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       IF_ID_Rs,
  input  logic [3:0]       IF_ID_Rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_halt,
  input  logic             EX_memread,
  input  logic [3:0]       EX_regtowrite,
  input  logic             EX_branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             if_id_flush,
  output logic             id_ex_wen,
  output logic             id_ex_flush,
  output logic             ex_mem_wen,
  output logic             mem_wb_wen,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_hazard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A load into r0 never creates a dependency.
  assign lu_hazard = EX_memread && (EX_regtowrite != 4'd0) &&
                     ((ID_uses_rs && (EX_regtowrite == IF_ID_Rs)) ||
                      (ID_uses_rt && (EX_regtowrite == IF_ID_Rt)));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_wen      = 1'b0;
    if_id_wen   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_wen   = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_wen  = 1'b0;
    mem_wb_wen  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dmem_busy) begin
          // Full freeze: every register holds, nothing else is acted on.
        end else if (EX_branch_taken) begin
          pc_wen      = 1'b1;
          if_id_wen   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_wen   = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_wen  = 1'b1;
          mem_wb_wen  = 1'b1;
          flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (lu_hazard) begin
          // Hold PC and IF/ID, let the load move on with a bubble behind it.
          id_ex_wen   = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_wen  = 1'b1;
          mem_wb_wen  = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          // imem_busy: hold PC, feed a NOP into IF/ID. Rest of the pipe flows,
          // so an HLT already in ID may still advance and start the drain.
          pc_wen      = !imem_busy;
          if_id_wen   = 1'b1;
          if_id_flush = imem_busy;
          id_ex_wen   = 1'b1;
          ex_mem_wen  = 1'b1;
          mem_wb_wen  = 1'b1;
          if (imem_busy) stall_cnt_d = sat_inc(stall_cnt_q);
          if (ID_halt) begin
            state_d = DRAIN;
            drain_d = 4'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        if_id_wen   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_wen   = !dmem_busy;
        ex_mem_wen  = !dmem_busy;
        mem_wb_wen  = !dmem_busy;
        if (!dmem_busy) begin
          drain_d = drain_q - 4'd1;
          if (drain_q == 4'd1) state_d = HALTED;
        end
      end
      HALTED: begin
      end
      default: state_d = RUN;
    endcase

    // Controls are forced idle for as long as reset is held.
    if (rst) begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_wen   = 1'b0;
      id_ex_flush = 1'b0;
      ex_mem_wen  = 1'b0;
      mem_wb_wen  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
